// File: rtl/distance_filter.sv
// rtl/distance_filter.sv - outlier-rejecting moving average with hysteretic near flag
// Optional rejected-sample counter enabled by DIST_FILTER_STATS_EN.
`timescale 1ns/1ps
module distance_filter #(
  parameter int SAMPLE_CYCLES = 10_000_000,
  parameter int WIN_LOG2      = 2,
  parameter int MAX_CM        = 400,
  parameter int NEAR_CM       = 30,
  parameter int FAR_CM        = 40,
  parameter int DEBOUNCE      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] distance,
  output logic [19:0] avg_cm,
  output logic        avg_stb,
  output logic        avg_valid,
  output logic        near
`ifdef DIST_FILTER_STATS_EN
  ,
  output logic [15:0] invalid_cnt
`endif
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SW    = 20 + WIN_LOG2;
  localparam int TW    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CYCLES - 1);

  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_nxt;

  logic [19:0]         d_q1, d_q2;
  logic [TW-1:0]       tick;
  logic                pending;
  logic [19:0]         win [DEPTH];
  logic [WIN_LOG2-1:0] wptr;
  logic [SW-1:0]       sum;
  logic                upd, upd_nxt;
  logic [3:0]          deb, deb_inc;
  logic                tick_hit, accept, sample_ok, take, fill_done;
  logic [19:0]         avg_new;

  assign tick_hit  = (tick == TICK_LAST);
  assign accept    = pending && (d_q1 == d_q2);
  assign sample_ok = (d_q2 != 20'd0) && (d_q2 <= 20'(MAX_CM));
  assign take      = accept && sample_ok;
  assign fill_done = (state == FILL) && take && (&wptr);
  assign avg_new   = sum[SW-1:WIN_LOG2];
  assign deb_inc   = deb + 4'd1;

  always_comb begin
    state_nxt = state;
    upd_nxt   = 1'b0;
    if (fill_done) state_nxt = RUN;
    // the sample that completes the fill already yields the first average
    if (take && (state == RUN || fill_done)) upd_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FILL;
      d_q1    <= '0;
      d_q2    <= '0;
      tick    <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      d_q1    <= distance;
      d_q2    <= d_q1;
      tick    <= tick_hit ? '0 : tick + TW'(1);
      // a tick landing on a pending sample is absorbed, not queued
      pending <= tick_hit | (pending & ~accept);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      wptr <= '0;
      sum  <= '0;
      upd  <= 1'b0;
    end else begin
      upd <= upd_nxt;
      if (take) begin
        // empty slots hold zero, so the same update works during fill
        win[wptr] <= d_q2;
        sum       <= sum + SW'(d_q2) - SW'(win[wptr]);
        wptr      <= wptr + WIN_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_cm    <= '0;
      avg_stb   <= 1'b0;
      avg_valid <= 1'b0;
      near      <= 1'b0;
      deb       <= '0;
    end else begin
      avg_stb <= upd;
      if (upd) begin
        avg_cm    <= avg_new;
        avg_valid <= 1'b1;
        if (!near && avg_new < 20'(NEAR_CM)) begin
          if (deb_inc == 4'(DEBOUNCE)) begin
            near <= 1'b1;
            deb  <= '0;
          end else begin
            deb <= deb_inc;
          end
        end else if (near && avg_new >= 20'(FAR_CM)) begin
          if (deb_inc == 4'(DEBOUNCE)) begin
            near <= 1'b0;
            deb  <= '0;
          end else begin
            deb <= deb_inc;
          end
        end else begin
          deb <= '0;
        end
      end
    end
  end

`ifdef DIST_FILTER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      invalid_cnt <= '0;
    end else if (accept && !sample_ok && invalid_cnt != 16'hFFFF) begin
      invalid_cnt <= invalid_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_distance_filter.sv
// tb/tb_distance_filter.sv - randomized self-checking bench for distance_filter
`timescale 1ns/1ps
module tb_distance_filter;

  localparam int SAMPLE_CYCLES = 8;
  localparam int WIN_LOG2      = 2;
  localparam int DEPTH         = 1 << WIN_LOG2;
  localparam int MAX_CM        = 400;
  localparam int NEAR_CM       = 30;
  localparam int FAR_CM        = 40;
  localparam int DEBOUNCE      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] distance = 20'd100;
  logic [19:0] avg_cm;
  logic        avg_stb;
  logic        avg_valid;
  logic        near;
`ifdef DIST_FILTER_STATS_EN
  logic [15:0] invalid_cnt;
`endif

  always #5 clk = ~clk;

  distance_filter #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES),
    .WIN_LOG2(WIN_LOG2),
    .MAX_CM(MAX_CM),
    .NEAR_CM(NEAR_CM),
    .FAR_CM(FAR_CM),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .distance(distance),
    .avg_cm(avg_cm),
    .avg_stb(avg_stb),
    .avg_valid(avg_valid),
    .near(near)
`ifdef DIST_FILTER_STATS_EN
    ,
    .invalid_cnt(invalid_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // reference: last DEPTH valid samples, their mean, and the near-flag rules
  int q[$];
  int exp_avg, exp_deb, exp_inv;
  bit exp_valid, exp_near, exp_stb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_avg = 0; exp_deb = 0; exp_inv = 0;
    exp_valid = 0; exp_near = 0; exp_stb = 0;
  endtask

  task automatic model_accept(input int v);
    int s;
    exp_stb = 0;
    if (v == 0 || v > MAX_CM) begin
      if (exp_inv < 65535) exp_inv++;
      return;
    end
    q.push_back(v);
    if (q.size() > DEPTH) void'(q.pop_front());
    if (q.size() == DEPTH) begin
      s = 0;
      foreach (q[i]) s += q[i];
      exp_avg   = s / DEPTH;
      exp_valid = 1;
      exp_stb   = 1;
      if (!exp_near && exp_avg < NEAR_CM) begin
        exp_deb++;
        if (exp_deb == DEBOUNCE) begin exp_near = 1; exp_deb = 0; end
      end else if (exp_near && exp_avg >= FAR_CM) begin
        exp_deb++;
        if (exp_deb == DEBOUNCE) begin exp_near = 0; exp_deb = 0; end
      end else begin
        exp_deb = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_stb"}, 32'(avg_stb), 32'(exp_stb));
    check({tag, "_avg"}, 32'(avg_cm), exp_avg);
    check({tag, "_valid"}, 32'(avg_valid), 32'(exp_valid));
    check({tag, "_near"}, 32'(near), 32'(exp_near));
`ifdef DIST_FILTER_STATS_EN
    check({tag, "_inv"}, 32'(invalid_cnt), exp_inv);
`endif
  endtask

  // entered 3 edges after a tick-period boundary; acceptance falls on edge 8k
  task automatic run_period(input int v, input string tag);
    distance = 20'(v);
    model_accept(v);
    repeat (6) step();
    check({tag, "_early"}, 32'(avg_stb), 0);
    step();
    check_outputs(tag);
    step();
    check({tag, "_width"}, 32'(avg_stb), 0);
  endtask

  task automatic unstable_period();
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      distance = (k % 2 == 1) ? 20'd321 : 20'd123;
      step();
    end
    distance = 20'd60;
    model_accept(60);
    repeat (3) begin
      step();
      check("unstable_defer", 32'(avg_stb), 0);
    end
    step();
    check_outputs("unstable_first");
    step();
    check("unstable_width", 32'(avg_stb), 0);
    model_accept(60);
    repeat (2) step();
    check_outputs("unstable_next");
    step();
    check("unstable_width2", 32'(avg_stb), 0);
  endtask

  initial begin
    int r, v;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_avg", 32'(avg_cm), 0);
    check("reset_valid", 32'(avg_valid), 0);
    check("reset_near", 32'(near), 0);
    check("reset_stb", 32'(avg_stb), 0);
    rst = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 4; i++) run_period(100, "fill");
    for (int i = 0; i < 5; i++) run_period(20, "approach");
    for (int i = 0; i < 4; i++) run_period(36, "hyst_hold");
    for (int i = 0; i < 3; i++) run_period(50, "hyst_clear");
    for (int i = 0; i < 4; i++) run_period(100, "refill");
    run_period(0, "outlier_zero");
    run_period(500, "outlier_big");
    unstable_period();

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      v = 0;
      else if (r == 1) v = int'($urandom_range(401, 2000));
      else if (r == 2) v = int'($urandom_range(31, 400));
      else             v = int'($urandom_range(1, 60));
      run_period(v, "random");
    end

    for (int i = 0; i < 6; i++) run_period(20, "pre_reset");
    check("pre_reset_near_set", 32'(near), 1);
    distance = 20'd20;
    repeat (6) step();
    rst = 1'b0;
    #1;
    check("async_avg", 32'(avg_cm), 0);
    check("async_valid", 32'(avg_valid), 0);
    check("async_near", 32'(near), 0);
    check("async_stb", 32'(avg_stb), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 4; i++) run_period(100, "refill_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
Name: distance_filter

Overview:
- Consumes the raw 20-bit centimetre distance from the ultrasonic front end.
- Produces a debounced, outlier-rejected moving average plus a hysteretic "near obstacle" flag for the display and control logic.
- Safely samples the distance bus, which is produced in the 1 MHz derived domain, inside the 100 MHz system clock domain.

Parameters:
- SAMPLE_CYCLES, 10_000_000: clk cycles between sample attempts (100 ms at 100 MHz).
- WIN_LOG2, 2: log2 of the averaging window depth (default 4 samples).
- MAX_CM, 400: largest distance accepted as valid.
- NEAR_CM, 30: `near` asserts when the average is below this value.
- FAR_CM, 40: `near` deasserts when the average is at or above this value. Must be > NEAR_CM.
- DEBOUNCE, 2: consecutive qualifying averages needed to toggle `near`. Range 1..15.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- distance  input  20  raw distance in cm from the sensor front end
- avg_cm  output  20  filtered average in cm
- avg_stb  output  1  one-cycle pulse when avg_cm updates
- avg_valid  output  1  high once the window has been filled
- near  output  1  debounced, hysteretic obstacle flag
- invalid_cnt  output  16  rejected-sample counter (only with DIST_FILTER_STATS_EN)

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, window and sum cleared, state FILL, tick counter 0, debounce counter 0. All state resumes on the first clk edge after rst returns to 1.
- Input capture: distance is registered every cycle into d_q1, then into d_q2. A bus is "stable" in a cycle when d_q1 == d_q2.
- Tick counter: runs 0..SAMPLE_CYCLES-1 and wraps. At SAMPLE_CYCLES-1 it sets `pending`.
- Acceptance: while `pending` is set and the bus is stable, d_q2 is taken as the sample in that cycle (cycle A) and `pending` clears. If the bus is unstable, acceptance is deferred cycle by cycle. A new tick while still pending is absorbed; there is no double sample.
- Validity: a sample of 0 or > MAX_CM is invalid. An invalid sample:
  - leaves the window, sum, debounce counter and outputs unchanged;
  - does not pulse avg_stb;
  - increments invalid_cnt (when the feature is enabled).
- Window: circular buffer of 2^WIN_LOG2 x 20 bits with a write pointer that wraps modulo the depth. Sum width is 20+WIN_LOG2 bits and never overflows.
- State FILL:
  - A valid sample is written at the pointer; sum += sample at A+1; fill count increments.
  - When fill count reaches 2^WIN_LOG2, go to RUN.
  - No avg_stb pulses in FILL.
- State RUN:
  - A valid sample replaces the oldest entry; sum = sum + new - oldest at A+1.
  - At A+2: avg_cm = sum >> WIN_LOG2 (truncating), and avg_stb pulses.
  - On the first RUN update, avg_valid rises at A+2 and stays high until reset.
- Hysteresis, evaluated at A+2 from the new average:
  - near=0 and avg < NEAR_CM: increment deb. When deb reaches DEBOUNCE, near<=1 and deb<=0.
  - near=1 and avg >= FAR_CM: increment deb. When deb reaches DEBOUNCE, near<=0 and deb<=0.
  - Any other case: deb<=0.
- Fill-completion update: the sample that completes FILL itself produces the first avg_stb, avg_valid and hysteresis evaluation at A+2.
- Tick during update: a tick arriving during the A..A+2 pipeline sets `pending` normally. Back-to-back samples are legal only when SAMPLE_CYCLES >= 4.

Optional Feature:
- Macro DIST_FILTER_STATS_EN.
- Defined: the invalid_cnt port exists. It increments on every rejected sample, saturates at 0xFFFF, and resets to 0.
- Undefined: no port, no counter logic. Rejection behaviour is otherwise identical.

Test Plan:
Bench parameters: SAMPLE_CYCLES=8, WIN_LOG2=2, MAX_CM=400, NEAR_CM=30, FAR_CM=40, DEBOUNCE=2.
- Fill: release reset with distance=100 constant. No avg_stb for the first 3 accepted samples. On the 4th: avg_valid=1, avg_cm=100, near=0, and avg_stb is a single-cycle pulse 2 cycles after acceptance.
- Approach: after fill, distance=20. avg_cm sequence 80, 60, 40, 20, 20. near rises on the 5th post-change sample, the second consecutive avg < 30.
- Hysteresis: with near=1, distance=36 gives averages below 40, so near stays 1. Then distance=50: near clears only after two consecutive avg >= 40.
- Outliers: with the window at 100, inject one sample of 0 and one of 500. avg_cm stays 100, no avg_stb for either, and invalid_cnt goes 0 → 1 → 2 (macro defined).
- Unstable bus: toggle distance every clk around a tick for 5 cycles, then hold at 60. Acceptance is deferred until d_q1 == d_q2, exactly one sample of 60 is taken, and no corrupt value enters the window.
- Reset mid-run: drive rst=0 in the cycle between acceptance and avg_stb. avg_cm, avg_valid, near and avg_stb go 0 immediately without a clk edge. After release, 4 new valid samples are required before avg_valid returns.
